// File: rtl/ram8k_arbiter_pkg.sv
// Shared definitions for the two-port RAM8K arbiter: widths, state and
// priority-pointer encodings, and the latched command payload.
package ram8k_arbiter_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } ptr_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Round-robin: after a grant, priority moves to the requester that lost.
  function automatic ptr_t other_ptr(input logic granted_b);
    return granted_b ? REQ_A : REQ_B;
  endfunction

endpackage

// File: rtl/ram8k_arbiter_rr_pick2.sv
// Two-way round-robin picker: a sole requester wins; on a tie the
// requester named by ptr wins.
module rr_pick2
  import ram8k_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic ptr,
  output logic sel_a,
  output logic sel_b,
  output logic any
);

  always_comb begin
    any   = a_req | b_req;
    sel_a = a_req & (~b_req | (ptr == REQ_A));
    sel_b = b_req & (~a_req | (ptr == REQ_B));
  end

endmodule

// File: rtl/ram8k_arbiter.sv
// Arbitrates two requesters onto a single RAM8K port: one access per
// IDLE/BUSY pair, round-robin on ties, registered grant/read-valid pulses.
module ram8k_arbiter
  import ram8k_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [12:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [12:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [15:0] a_rdata,
  output logic [15:0] b_rdata,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic [12:0] ram_address,
  input  logic [15:0] ram_out
);

  state_t             r_state;
  state_t             w_state_nxt;
  ptr_t               r_ptr;
  ptr_t               w_ptr_nxt;
  cmd_t               r_cmd;
  cmd_t               w_cmd_nxt;
  logic               r_load;
  logic               w_load_nxt;
  logic               r_a_gnt;
  logic               w_a_gnt_nxt;
  logic               r_b_gnt;
  logic               w_b_gnt_nxt;
  logic               r_a_rvalid;
  logic               w_a_rvalid_nxt;
  logic               r_b_rvalid;
  logic               w_b_rvalid_nxt;
  logic [DATA_W-1:0]  r_a_rdata;
  logic [DATA_W-1:0]  w_a_rdata_nxt;
  logic [DATA_W-1:0]  r_b_rdata;
  logic [DATA_W-1:0]  w_b_rdata_nxt;
  logic               w_sel_a;
  logic               w_sel_b;
  logic               w_any;

  rr_pick2 u_pick (
    .a_req (a_req),
    .b_req (b_req),
    .ptr   (r_ptr),
    .sel_a (w_sel_a),
    .sel_b (w_sel_b),
    .any   (w_any)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = BUSY;
      BUSY:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and latched command
  always_comb begin
    w_cmd_nxt      = r_cmd;
    w_ptr_nxt      = r_ptr;
    w_load_nxt     = 1'b0;
    w_a_gnt_nxt    = 1'b0;
    w_b_gnt_nxt    = 1'b0;
    w_a_rvalid_nxt = 1'b0;
    w_b_rvalid_nxt = 1'b0;
    w_a_rdata_nxt  = r_a_rdata;
    w_b_rdata_nxt  = r_b_rdata;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_sel_a) begin
            w_cmd_nxt.we    = a_we;
            w_cmd_nxt.addr  = a_addr;
            w_cmd_nxt.wdata = a_wdata;
          end else begin
            w_cmd_nxt.we    = b_we;
            w_cmd_nxt.addr  = b_addr;
            w_cmd_nxt.wdata = b_wdata;
          end
          w_load_nxt  = w_cmd_nxt.we;
          w_a_gnt_nxt = w_sel_a;
          w_b_gnt_nxt = w_sel_b;
          w_ptr_nxt   = other_ptr(w_sel_b);
        end
      end
      BUSY: begin
        // RAM8K read is combinational on the held address; capture it now.
        if (!r_cmd.we) begin
          if (r_a_gnt) begin
            w_a_rvalid_nxt = 1'b1;
            w_a_rdata_nxt  = ram_out;
          end
          if (r_b_gnt) begin
            w_b_rvalid_nxt = 1'b1;
            w_b_rdata_nxt  = ram_out;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and command registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd      <= '0;
      r_ptr      <= REQ_A;
      r_load     <= 1'b0;
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_cmd      <= w_cmd_nxt;
      r_ptr      <= w_ptr_nxt;
      r_load     <= w_load_nxt;
      r_a_gnt    <= w_a_gnt_nxt;
      r_b_gnt    <= w_b_gnt_nxt;
      r_a_rvalid <= w_a_rvalid_nxt;
      r_b_rvalid <= w_b_rvalid_nxt;
      r_a_rdata  <= w_a_rdata_nxt;
      r_b_rdata  <= w_b_rdata_nxt;
    end
  end

  assign a_gnt       = r_a_gnt;
  assign b_gnt       = r_b_gnt;
  assign a_rvalid    = r_a_rvalid;
  assign b_rvalid    = r_b_rvalid;
  assign a_rdata     = r_a_rdata;
  assign b_rdata     = r_b_rdata;
  assign ram_load    = r_load;
  assign ram_address = r_cmd.addr;
  assign ram_in      = r_cmd.wdata;

endmodule

// File: tb/tb_ram8k_arbiter.sv
// Bench for ram8k_arbiter with a behavioural RAM8K: directed vector table,
// reset corner sequences, then random traffic against a transaction model.
module tb_ram8k_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [12:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [12:0] ram_address;
  logic [15:0] ram_out;

  int n_chk = 0;
  int n_err = 0;

  ram8k_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM8K: combinational read, write on the rising edge, no reset.
  logic [15:0] mem [0:8191];
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  // Transaction-level reference: one pending access at most, shadow memory.
  logic [15:0] shadow [0:8191];
  bit          m_busy = 1'b0;
  bit          m_we = 1'b0;
  bit          m_win_b = 1'b0;
  bit          m_prio_b = 1'b0;
  logic [12:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  bit          e_ag = 1'b0, e_bg = 1'b0, e_av = 1'b0, e_bv = 1'b0;
  logic [15:0] e_ard = '0, e_brd = '0;

  task automatic model_edge();
    e_ag = 1'b0; e_bg = 1'b0; e_av = 1'b0; e_bv = 1'b0;
    if (m_busy && m_we) shadow[m_addr] = m_wdata;
    if (reset) begin
      m_busy = 1'b0; m_prio_b = 1'b0; e_ard = '0; e_brd = '0;
    end else if (m_busy) begin
      m_busy = 1'b0;
      if (!m_we) begin
        if (m_win_b) begin e_bv = 1'b1; e_brd = shadow[m_addr]; end
        else         begin e_av = 1'b1; e_ard = shadow[m_addr]; end
      end
    end else if (a_req || b_req) begin
      m_win_b = b_req && (!a_req || m_prio_b);
      m_we    = m_win_b ? b_we    : a_we;
      m_addr  = m_win_b ? b_addr  : a_addr;
      m_wdata = m_win_b ? b_wdata : a_wdata;
      m_prio_b = !m_win_b;
      m_busy  = 1'b1;
      e_ag = !m_win_b; e_bg = m_win_b;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_a(input logic rq, input logic we, input logic [12:0] ad, input logic [15:0] d);
    a_req = rq; a_we = we; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic rq, input logic we, input logic [12:0] ad, input logic [15:0] d);
    b_req = rq; b_we = we; b_addr = ad; b_wdata = d;
  endtask

  typedef struct {
    logic        rst, ar, aw;
    logic [12:0] aa;
    logic [15:0] ad;
    logic        br, bw;
    logic [12:0] ba;
    logic [15:0] bd;
    logic        eag, ebg, eav, ebv, eld;
    logic [15:0] eard, ebrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, ar, aw, input int aa, ad,
                              input logic br, bw, input int ba, bd,
                              input logic eag, ebg, eav, ebv, eld,
                              input int eard, ebrd);
    vec_t v;
    v.rst = rst; v.ar = ar; v.aw = aw; v.aa = 13'(aa); v.ad = 16'(ad);
    v.br = br; v.bw = bw; v.ba = 13'(ba); v.bd = 16'(bd);
    v.eag = eag; v.ebg = ebg; v.eav = eav; v.ebv = ebv; v.eld = eld;
    v.eard = 16'(eard); v.ebrd = 16'(ebrd);
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " a_gnt"},    16'(a_gnt),    16'(e_ag));
    chk({tag, " b_gnt"},    16'(b_gnt),    16'(e_bg));
    chk({tag, " a_rvalid"}, 16'(a_rvalid), 16'(e_av));
    chk({tag, " b_rvalid"}, 16'(b_rvalid), 16'(e_bv));
    chk({tag, " a_rdata"},  a_rdata,       e_ard);
    chk({tag, " b_rdata"},  b_rdata,       e_brd);
    chk({tag, " ram_load"}, 16'(ram_load), 16'(m_busy && m_we));
  endtask

  function automatic logic [12:0] pick_addr();
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return 13'd0;
    if (k == 1) return 13'd8191;
    return 13'(k);
  endfunction

  int a_age = 0;
  int b_age = 0;

  initial begin
    for (int i = 0; i < 8192; i++) begin mem[i] = '0; shadow[i] = '0; end
    reset = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);

    //        rst ar aw aa    ad    br bw ba    bd    | ag bg av bv ld ard   brd
    tbl.push_back(mk(1, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 1, 1, 500,  500,  0, 0, 0,    0,    1, 0, 0, 0, 1, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 1, 0, 500,  0,    0, 0, 0,    0,    1, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 1, 0, 0, 500,  0));
    tbl.push_back(mk(1, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 1, 1, 1000, 1000, 1, 1, 8191, 8091, 1, 0, 0, 0, 1, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    1, 1, 8191, 8091, 0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    1, 1, 8191, 8091, 0, 1, 0, 0, 1, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 1, 0, 1000, 0,    0, 0, 0,    0,    1, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 1, 0, 0, 1000, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    1, 0, 8191, 0,    0, 1, 0, 0, 0, 1000, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 1, 0, 1000, 8091));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    1, 0, 0, 0, 0, 1000, 8091));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    0, 0, 1, 0, 0, 0,    8091));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    0, 1, 0, 0, 0, 0,    8091));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    0, 0, 0, 1, 0, 0,    0));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    1, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    0, 0, 1, 0, 0, 0,    0));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    0, 1, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 1, 0, 0,    0,    1, 0, 1,    0,    0, 0, 0, 1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    1, 1, 7777, 7777, 0, 1, 0, 0, 1, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    1, 0, 7777, 0,    0, 1, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0, 0,    0,    0, 0, 0,    0,    0, 0, 0, 1, 0, 0,    7777));

    @(negedge clk);
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      set_a(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad);
      set_b(tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      cycle();
      chk($sformatf("row%0d a_gnt", i),    16'(a_gnt),    16'(tbl[i].eag));
      chk($sformatf("row%0d b_gnt", i),    16'(b_gnt),    16'(tbl[i].ebg));
      chk($sformatf("row%0d a_rvalid", i), 16'(a_rvalid), 16'(tbl[i].eav));
      chk($sformatf("row%0d b_rvalid", i), 16'(b_rvalid), 16'(tbl[i].ebv));
      chk($sformatf("row%0d ram_load", i), 16'(ram_load), 16'(tbl[i].eld));
      chk($sformatf("row%0d a_rdata", i),  a_rdata,       tbl[i].eard);
      chk($sformatf("row%0d b_rdata", i),  b_rdata,       tbl[i].ebrd);
    end

    // Reset lands on the BUSY cycle of a read while A still requests.
    reset = 1'b0; set_b(0, 0, 0, 0);
    set_a(1, 0, 6666, 0);
    cycle();
    chk("rdrst gnt", 16'(a_gnt), 16'd1);
    chk("rdrst addr", 16'(ram_address), 16'd6666);
    reset = 1'b1;
    cycle();
    chk("rdrst a_gnt", 16'(a_gnt), 16'd0);
    chk("rdrst b_gnt", 16'(b_gnt), 16'd0);
    chk("rdrst a_rvalid", 16'(a_rvalid), 16'd0);
    chk("rdrst b_rvalid", 16'(b_rvalid), 16'd0);
    chk("rdrst a_rdata", a_rdata, 16'd0);
    chk("rdrst b_rdata", b_rdata, 16'd0);
    chk("rdrst ram_load", 16'(ram_load), 16'd0);
    chk("rdrst ram_address", 16'(ram_address), 16'd0);
    chk("rdrst ram_in", ram_in, 16'd0);
    reset = 1'b0; set_a(0, 0, 0, 0);
    cycle();
    chk("rdrst late rvalid", 16'(a_rvalid), 16'd0);
    set_b(1, 0, 7777, 0);
    cycle();
    chk("rdrst idle b_gnt", 16'(b_gnt), 16'd1);
    set_b(0, 0, 0, 0);
    cycle();
    chk("rdrst b_rvalid", 16'(b_rvalid), 16'd1);
    chk("rdrst b_rdata2", b_rdata, 16'd7777);

    // Reset during a write still commits the write.
    set_a(1, 1, 3600, 3600);
    cycle();
    chk("wrrst gnt", 16'(a_gnt), 16'd1);
    chk("wrrst load", 16'(ram_load), 16'd1);
    reset = 1'b1; set_a(0, 0, 0, 0);
    cycle();
    chk("wrrst load clr", 16'(ram_load), 16'd0);
    reset = 1'b0;
    set_a(1, 0, 3600, 0);
    cycle();
    chk("wrrst rd gnt", 16'(a_gnt), 16'd1);
    set_a(0, 0, 0, 0);
    cycle();
    chk("wrrst rvalid", 16'(a_rvalid), 16'd1);
    chk("wrrst rdata", a_rdata, 16'd3600);

    // Random traffic with occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      if (reset) begin a_age = 0; b_age = 0; end
      if (a_req) begin
        if (a_gnt) begin
          chk("a_starve", 16'(a_age <= 4), 16'd1);
          a_age = 0;
          if ($urandom_range(0, 1) == 0) a_req = 1'b0;
          else set_a(1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
        end else a_age++;
      end else if ($urandom_range(0, 2) == 0)
        set_a(1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
      if (b_req) begin
        if (b_gnt) begin
          chk("b_starve", 16'(b_age <= 4), 16'd1);
          b_age = 0;
          if ($urandom_range(0, 1) == 0) b_req = 1'b0;
          else set_b(1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
        end else b_age++;
      end else if ($urandom_range(0, 2) == 0)
        set_b(1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
      reset = ($urandom_range(0, 99) == 0);
      cycle();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
